mem_xfer_fsm: RTL and testbench

MEM_XFER_FSM -- requirements
Module: mem_xfer_fsm

---
 rtl/mem_xfer_fsm_pkg.sv | 32 +++
 rtl/mem_xfer_fsm_reg_sel_decode.sv | 21 ++
 rtl/mem_xfer_fsm.sv | 198 +++++++++++++++++++
 tb/tb_mem_xfer_fsm.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_xfer_fsm_pkg.sv
// Shared definitions for the memory-transfer controller.
//   state_t          : controller state enumeration
//   OP_LOAD/OP_STORE : values of the op input
//   sel_bit()        : one bit of the register-select decode
package mem_xfer_fsm_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_SDATA,
    S_WAIT_R,
    S_READ,
    S_WB,
    S_WAIT_W,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  // Bit k of decode(p) for an nreg-wide one-hot.
  // Selects 1..nreg-1 map to bits 0..nreg-2.
  // Zero and every out-of-range select fall onto the top register.
  function automatic logic sel_bit(input logic [31:0] p, input int nreg, input int k);
    if (k == nreg - 1) begin
      return (p == 32'd0) || (p >= $unsigned(nreg));
    end
    return p == $unsigned(k + 1);
  endfunction

endpackage

// File: rtl/mem_xfer_fsm_reg_sel_decode.sv
// Register-select decoder: turns a SEL_W-bit select into an NREG-bit one-hot.
//   sel    : register select field
//   onehot : one-hot register enable vector (exactly one bit set)
module reg_sel_decode
  import mem_xfer_fsm_pkg::*;
#(
  parameter int NREG  = 4,
  parameter int SEL_W = 6
) (
  input  logic [SEL_W-1:0] sel,
  output logic [NREG-1:0]  onehot
);

  logic [31:0] sel_ext;
  assign sel_ext = 32'(sel);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
    assign onehot[gi] = sel_bit(sel_ext, NREG, gi);
  end

endmodule

// File: rtl/mem_xfer_fsm.sv
// Load/store transfer controller between a register file and memory.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   start, op            : transfer request and direction (0 load, 1 store)
//   MFC                  : memory function complete
//   p1, p2               : address-register and data-register selects
//   PCinc..memOp         : datapath strobes (memOp 1 = read, 0 = write)
//   RiOut, RjIn          : one-hot register output / input enables
//   finish, error, busy  : completion pulse, timeout pulse, not-idle flag
// All outputs are registered and decoded from the next state, so they are
// Moore outputs of the current state with no combinational path from inputs.
module mem_xfer_fsm
  import mem_xfer_fsm_pkg::*;
#(
  parameter int NREG    = 4,
  parameter int SEL_W   = 6,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic             MFC,
  input  logic [SEL_W-1:0] p1,
  input  logic [SEL_W-1:0] p2,
  output logic             PCinc,
  output logic             MARin,
  output logic             MDRread,
  output logic             MDRin,
  output logic             MDRout,
  output logic             memEn,
  output logic             memOp,
  output logic [NREG-1:0]  RiOut,
  output logic [NREG-1:0]  RjIn,
  output logic             finish,
  output logic             error,
  output logic             busy
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [NREG-1:0] dec1, dec2;

  reg_sel_decode #(.NREG(NREG), .SEL_W(SEL_W)) u_dec_p1 (.sel(p1), .onehot(dec1));
  reg_sel_decode #(.NREG(NREG), .SEL_W(SEL_W)) u_dec_p2 (.sel(p2), .onehot(dec2));

  state_t          state_q, state_d;
  logic            op_q, op_d;
  logic [NREG-1:0] sel1_q, sel1_d, sel2_q, sel2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pcinc_q, pcinc_d, marin_q, marin_d, mdrread_q, mdrread_d;
  logic mdrin_q, mdrin_d, mdrout_q, mdrout_d, memen_q, memen_d;
  logic memop_q, memop_d, finish_q, finish_d, error_q, error_d, busy_q, busy_d;
  logic [NREG-1:0] riout_q, riout_d, rjin_q, rjin_d;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel1_d  = sel1_q;
    sel2_d  = sel2_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          sel1_d  = dec1;
          sel2_d  = dec2;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_d   = '0;
        state_d = (op_q == OP_STORE) ? S_SDATA : S_WAIT_R;
      end
      S_SDATA: begin
        cnt_d   = '0;
        state_d = S_WAIT_W;
      end
      S_WAIT_R, S_WAIT_W: begin
        // MFC takes priority over the timeout on the last permitted cycle.
        if (MFC) begin
          state_d = (state_q == S_WAIT_R) ? S_READ : S_DONE;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_READ:  state_d = S_WB;
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the next state; sel*_d is used because the selects
  // are captured on the same edge that enters ADDR.
  always_comb begin
    pcinc_d   = 1'b0;
    marin_d   = 1'b0;
    mdrread_d = 1'b0;
    mdrin_d   = 1'b0;
    mdrout_d  = 1'b0;
    memen_d   = 1'b0;
    memop_d   = 1'b0;
    riout_d   = '0;
    rjin_d    = '0;
    finish_d  = 1'b0;
    error_d   = 1'b0;
    busy_d    = (state_d != S_IDLE);
    unique case (state_d)
      S_ADDR: begin
        pcinc_d = 1'b1;
        marin_d = 1'b1;
        riout_d = sel1_d;
      end
      S_SDATA: begin
        riout_d = sel2_d;
        mdrin_d = 1'b1;
      end
      S_WAIT_R: begin
        memen_d = 1'b1;
        memop_d = 1'b1;
      end
      S_READ: begin
        memen_d   = 1'b1;
        memop_d   = 1'b1;
        mdrread_d = 1'b1;
      end
      S_WB: begin
        mdrout_d = 1'b1;
        rjin_d   = sel2_d;
      end
      S_WAIT_W: memen_d  = 1'b1;
      S_DONE:   finish_d = 1'b1;
      S_ERR:    error_d  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= 1'b0;
      sel1_q    <= '0;
      sel2_q    <= '0;
      cnt_q     <= '0;
      pcinc_q   <= 1'b0;
      marin_q   <= 1'b0;
      mdrread_q <= 1'b0;
      mdrin_q   <= 1'b0;
      mdrout_q  <= 1'b0;
      memen_q   <= 1'b0;
      memop_q   <= 1'b0;
      riout_q   <= '0;
      rjin_q    <= '0;
      finish_q  <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
      cnt_q     <= cnt_d;
      pcinc_q   <= pcinc_d;
      marin_q   <= marin_d;
      mdrread_q <= mdrread_d;
      mdrin_q   <= mdrin_d;
      mdrout_q  <= mdrout_d;
      memen_q   <= memen_d;
      memop_q   <= memop_d;
      riout_q   <= riout_d;
      rjin_q    <= rjin_d;
      finish_q  <= finish_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end

  assign PCinc   = pcinc_q;
  assign MARin   = marin_q;
  assign MDRread = mdrread_q;
  assign MDRin   = mdrin_q;
  assign MDRout  = mdrout_q;
  assign memEn   = memen_q;
  assign memOp   = memop_q;
  assign RiOut   = riout_q;
  assign RjIn    = rjin_q;
  assign finish  = finish_q;
  assign error   = error_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_xfer_fsm.sv
// Self-checking bench for mem_xfer_fsm. Each transfer is described by
// (op, p1, p2, number of MFC-low wait cycles) and the expected per-cycle
// output trace is derived from the state walk described for the controller.
module tb_mem_xfer_fsm;
  localparam int NREG = 4, SEL_W = 6, TIMEOUT = 16;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, op = 1'b0, MFC = 1'b0;
  logic [SEL_W-1:0] p1 = '0, p2 = '0;
  logic PCinc, MARin, MDRread, MDRin, MDRout, memEn, memOp, finish, error, busy;
  logic [NREG-1:0] RiOut, RjIn;

  int checks = 0, errors = 0, xfer_no = 0;

  typedef struct packed {
    logic pcinc, marin, mdrread, mdrin, mdrout, memen, memop;
    logic [NREG-1:0] riout, rjin;
    logic fin, err, bsy;
  } ov_t;

  ov_t exp_q[$];
  bit  mfc_q[$];

  mem_xfer_fsm #(.NREG(NREG), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .MFC(MFC),
    .p1(p1), .p2(p2), .PCinc(PCinc), .MARin(MARin), .MDRread(MDRread),
    .MDRin(MDRin), .MDRout(MDRout), .memEn(memEn), .memOp(memOp),
    .RiOut(RiOut), .RjIn(RjIn), .finish(finish), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [NREG-1:0] ref_sel(input int p);
    if (p >= 1 && p <= NREG - 1) return NREG'(1 << (p - 1));
    return NREG'(1 << (NREG - 1));
  endfunction

  function automatic ov_t observed();
    return {PCinc, MARin, MDRread, MDRin, MDRout, memEn, memOp, RiOut, RjIn, finish, error, busy};
  endfunction

  task automatic check(input string tag, input int k, input ov_t exp);
    ov_t obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // Expected trace: one entry per clock cycle after the start is accepted.
  task automatic build(input bit o, input logic [NREG-1:0] s1, input logic [NREG-1:0] s2, input int d);
    ov_t v;
    int nwait;
    exp_q.delete();
    mfc_q.delete();
    v = '0; v.bsy = 1; v.pcinc = 1; v.marin = 1; v.riout = s1;
    exp_q.push_back(v); mfc_q.push_back(1'($urandom));
    if (o) begin
      v = '0; v.bsy = 1; v.riout = s2; v.mdrin = 1;
      exp_q.push_back(v); mfc_q.push_back(1'($urandom));
    end
    nwait = (d < TIMEOUT) ? d + 1 : TIMEOUT;
    for (int w = 0; w < nwait; w++) begin
      v = '0; v.bsy = 1; v.memen = 1; v.memop = !o;
      exp_q.push_back(v); mfc_q.push_back(w == d);
    end
    if (d >= TIMEOUT) begin
      v = '0; v.bsy = 1; v.err = 1;
      exp_q.push_back(v); mfc_q.push_back(1'($urandom));
    end else begin
      if (!o) begin
        v = '0; v.bsy = 1; v.memen = 1; v.memop = 1; v.mdrread = 1;
        exp_q.push_back(v); mfc_q.push_back(1'($urandom));
        v = '0; v.bsy = 1; v.mdrout = 1; v.rjin = s2;
        exp_q.push_back(v); mfc_q.push_back(1'($urandom));
      end
      v = '0; v.bsy = 1; v.fin = 1;
      exp_q.push_back(v); mfc_q.push_back(1'($urandom));
    end
  endtask

  // Runs one transfer from an IDLE cycle. stop_k >= 0 leaves after that step.
  task automatic run_xfer(input string tag, input bit o, input int a, input int b,
                          input int d, input bit hold, input int stop_k);
    @(negedge clk);
    check({tag, "_idle"}, -1, '0);
    start = 1'b1; op = o; p1 = SEL_W'(a); p2 = SEL_W'(b); MFC = 1'($urandom);
    build(o, ref_sel(a), ref_sel(b), d);
    xfer_no++;
    $display("xfer %0d %s op=%0d p1=%0d p2=%0d mfc_delay=%0d hold=%0d cycles=%0d outcome=%s",
             xfer_no, tag, o, a, b, d, hold, exp_q.size(),
             (d >= TIMEOUT) ? "timeout" : "finish");
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      check(tag, k, exp_q[k]);
      if (k == stop_k) return;
      start = hold ? 1'b1 : 1'($urandom);
      op    = 1'($urandom);
      p1    = SEL_W'($urandom);
      p2    = SEL_W'($urandom);
      MFC   = mfc_q[k];
    end
    start = hold;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 check("reset", 0, '0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Directed cases
    run_xfer("load_2_3",      1'b0, 2, 3, 3,  1'b0, -1);
    run_xfer("store_1_0",     1'b1, 1, 0, 0,  1'b0, -1);
    run_xfer("load_fast",     1'b0, 1, 2, 0,  1'b0, -1);
    run_xfer("load_timeout",  1'b0, 3, 1, 40, 1'b0, -1);
    run_xfer("store_timeout", 1'b1, 0, 9, 16, 1'b0, -1);
    run_xfer("load_mfc_last", 1'b0, 2, 7, 15, 1'b0, -1);
    run_xfer("store_mfc_last",1'b1, 3, 3, 15, 1'b0, -1);
    run_xfer("hold_start_a",  1'b0, 1, 3, 2,  1'b1, -1);
    run_xfer("hold_start_b",  1'b1, 2, 4, 1,  1'b1, -1);
    run_xfer("hold_start_c",  1'b0, 63, 0, 0, 1'b0, -1);

    // Asynchronous reset in the middle of a load wait
    run_xfer("load_aborted",  1'b0, 2, 1, 40, 1'b0, 3);
    #2 reset_n = 1'b0;
    #1 check("async_reset", 0, '0);
    @(posedge clk);
    #1 check("reset_held", 0, '0);
    start = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    run_xfer("load_after_rst", 1'b0, 3, 2, 1, 1'b0, -1);

    // Randomized transfers
    for (int i = 0; i < 24; i++) begin
      run_xfer("random", 1'($urandom), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
               int'($urandom_range(0, 19)), 1'($urandom), -1);
    end

    start = 1'b0;
    @(negedge clk);
    check("final_idle", 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
